// File: rtl/hwpe_ctrl_ucode_dispatch.sv
// Microcode dispatch: captures offset sets from the microcode processor into a
// small descriptor FIFO and throttles the processor so no set is ever lost.
module hwpe_ctrl_ucode_dispatch #(
  parameter int unsigned NB_REG     = 4,
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        start_i,
  output logic                        ucode_enable_o,
  output logic                        ucode_clear_o,
  input  logic                        ucode_valid_i,
  input  logic                        ucode_done_i,
  input  logic                        ucode_accum_i,
  input  logic [NB_REG*REG_WIDTH-1:0] ucode_offs_i,
  output logic                        desc_valid_o,
  input  logic                        desc_ready_i,
  output logic [NB_REG*REG_WIDTH-1:0] desc_offs_o,
  output logic                        desc_accum_o,
  output logic                        desc_last_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  localparam int unsigned OFFS_W = NB_REG * REG_WIDTH;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  // Handshake: a descriptor transfers on a cycle where desc_valid_o & desc_ready_i;
  // while valid is high and ready low, the head entry and its fields stay stable.

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_e;

  typedef struct packed {
    logic [OFFS_W-1:0] offs;
    logic              accum;
    logic              last;
  } entry_t;

  state_e             state_q, state_d;
  entry_t             mem_q [FIFO_DEPTH];
  entry_t             head;
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, done_q, done_d;
  logic               push, pop, full, wr_en, overflow;

  assign push     = ucode_valid_i & ((state_q == RUN) | (state_q == DRAIN));
  assign pop      = desc_valid_o & desc_ready_i;
  assign full     = (cnt_q == CNT_W'(FIFO_DEPTH));
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en    = push & (~full | pop);
  assign overflow = push & full & ~pop;
  assign cnt_d    = cnt_q + CNT_W'(wr_en) - CNT_W'(pop);

  assign head         = mem_q[rptr_q];
  assign desc_valid_o = (cnt_q != '0);
  assign desc_offs_o  = desc_valid_o ? head.offs  : '0;
  assign desc_accum_o = desc_valid_o & head.accum;
  assign desc_last_o  = desc_valid_o & head.last;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;

  always_comb begin
    state_d        = state_q;
    ucode_enable_o = 1'b0;
    ucode_clear_o  = 1'b0;
    done_d         = 1'b0;
    case (state_q)
      IDLE:  if (start_i) state_d = CLEAR;
      CLEAR: begin
        ucode_clear_o = 1'b1;
        state_d       = RUN;
      end
      RUN: begin
        // Two free slots: one for this cycle, one for a set already in flight.
        ucode_enable_o = ((cnt_q - CNT_W'(pop)) <= CNT_W'(FIFO_DEPTH - 2));
        if (push && ucode_done_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (cnt_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else if (clear_i) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      if (wr_en) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)   rptr_q <= rptr_q + PTR_W'(1);
      if (overflow) err_q <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible when counted as occupied.
  always_ff @(posedge clk_i) begin
    if (wr_en && !clear_i) begin
      mem_q[wptr_q] <= '{offs: ucode_offs_i, accum: ucode_accum_i, last: ucode_done_i};
    end
  end

endmodule
